// File: rtl/soc_system_pio_in_edge.sv
// Avalon-MM input PIO: synchronised inputs, per-bit programmable edge detect,
// sticky capture register and masked level interrupt.
module soc_system_pio_in_edge #(
    parameter int          WIDTH         = 8,
    parameter int          SYNC_STAGES   = 2,
    parameter int          BIT_CLEAR     = 1,
    parameter logic [31:0] EDGE_MODE_RST = 32'h0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int         MW         = 2 * WIDTH;
    localparam logic [2:0] PRIME_DONE = 3'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [2:0]       prime_q, prime_d;
    logic [MW-1:0]    edge_mode_q, edge_mode_d;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] capture_q, capture_d;
    logic [31:0]      readdata_q, readdata_d;

    logic [WIDTH-1:0] s_now;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] clr_mask;
    logic             wr_en;
    logic             armed;
    logic             unused_wdata;

    assign s_now        = sync_q[SYNC_STAGES-1];
    assign wr_en        = chipselect & ~write_n;
    assign armed        = (prime_q == PRIME_DONE);
    assign unused_wdata = ^writedata;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], in_port};
        prev_d  = s_now;
        prime_d = armed ? prime_q : prime_q + 3'd1;
    end

    // Detection stays off until the chain and prev stage hold post-reset samples.
    always_comb begin
        edge_det = '0;
        for (int i = 0; i < WIDTH; i++) begin
            unique case (edge_mode_q[2*i +: 2])
                2'b00:   edge_det[i] = s_now[i] & ~prev_q[i];
                2'b01:   edge_det[i] = ~s_now[i] & prev_q[i];
                2'b10:   edge_det[i] = s_now[i] ^ prev_q[i];
                default: edge_det[i] = 1'b0;
            endcase
        end
        if (!armed) begin
            edge_det = '0;
        end
    end

    always_comb begin
        edge_mode_d = edge_mode_q;
        irq_mask_d  = irq_mask_q;
        clr_mask    = '0;
        if (wr_en && address == 2'd1) begin
            edge_mode_d = writedata[MW-1:0];
        end
        if (wr_en && address == 2'd2) begin
            irq_mask_d = writedata[WIDTH-1:0];
        end
        if (wr_en && address == 2'd3) begin
            clr_mask = (BIT_CLEAR != 0) ? writedata[WIDTH-1:0] : '1;
        end
        // A fresh edge wins over a simultaneous clear so no event is lost.
        capture_d = edge_det | (capture_q & ~clr_mask);
    end

    always_comb begin
        readdata_d = '0;
        unique case (address)
            2'd0:    readdata_d[WIDTH-1:0] = s_now;
            2'd1:    readdata_d[MW-1:0]    = edge_mode_q;
            2'd2:    readdata_d[WIDTH-1:0] = irq_mask_q;
            default: readdata_d[WIDTH-1:0] = capture_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q      <= '0;
            prev_q      <= '0;
            prime_q     <= '0;
            edge_mode_q <= EDGE_MODE_RST[MW-1:0];
            irq_mask_q  <= '0;
            capture_q   <= '0;
            readdata_q  <= '0;
        end else begin
            sync_q      <= sync_d;
            prev_q      <= prev_d;
            prime_q     <= prime_d;
            edge_mode_q <= edge_mode_d;
            irq_mask_q  <= irq_mask_d;
            capture_q   <= capture_d;
            readdata_q  <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(capture_q & irq_mask_q);

endmodule

// File: tb/tb_soc_system_pio_in_edge.sv
// Bench for soc_system_pio_in_edge: directed scenarios plus randomized bus and
// input traffic against a sample-history reference model.
module tb_soc_system_pio_in_edge;

    localparam int W = 8;
    localparam int S = 2;
    localparam int HMAX = 8192;

    logic        clk;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [W-1:0] in_port;
    logic        irq;

    logic [1:0]  address0;
    logic        chipselect0;
    logic        write_n0;
    logic [31:0] writedata0;
    logic [31:0] readdata0;
    logic [W-1:0] in_port0;
    logic        irq0;

    int errors = 0;
    int checks = 0;

    soc_system_pio_in_edge #(.WIDTH(W), .SYNC_STAGES(S), .BIT_CLEAR(1), .EDGE_MODE_RST(32'h0)) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .in_port(in_port), .irq(irq)
    );

    soc_system_pio_in_edge #(.WIDTH(W), .SYNC_STAGES(S), .BIT_CLEAR(0), .EDGE_MODE_RST(32'h0)) dut0 (
        .clk(clk), .reset(reset), .address(address0), .chipselect(chipselect0),
        .write_n(write_n0), .writedata(writedata0), .readdata(readdata0),
        .in_port(in_port0), .irq(irq0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model for dut: s is the input as sampled S clocks ago, p one
    // clock older; edges count only once both samples were taken after reset.
    logic [W-1:0]  m_samp [HMAX];
    int            m_n;
    logic [W-1:0]  m_cap;
    logic [W-1:0]  m_mask;
    logic [15:0]   m_mode;
    logic [31:0]   m_rd;

    function automatic logic [W-1:0] edges_of(input logic [W-1:0] s, input logic [W-1:0] p,
                                              input logic [15:0] mode);
        logic [W-1:0] e;
        e = '0;
        for (int i = 0; i < W; i++) begin
            case (mode[2*i +: 2])
                2'b00:   e[i] = s[i] && !p[i];
                2'b01:   e[i] = !s[i] && p[i];
                2'b10:   e[i] = s[i] != p[i];
                default: e[i] = 1'b0;
            endcase
        end
        return e;
    endfunction

    function automatic logic [W-1:0] m_s_now();
        return (m_n >= S) ? m_samp[m_n - S] : '0;
    endfunction

    function automatic logic [W-1:0] m_edges();
        if (m_n >= S + 1) return edges_of(m_samp[m_n - S], m_samp[m_n - S - 1], m_mode);
        return '0;
    endfunction

    function automatic logic [31:0] m_read(input logic [1:0] a);
        case (a)
            2'd0:    return {24'h0, m_s_now()};
            2'd1:    return {16'h0, m_mode};
            2'd2:    return {24'h0, m_mask};
            default: return {24'h0, m_cap};
        endcase
    endfunction

    function automatic logic [W-1:0] m_clear();
        if (chipselect && !write_n && address == 2'd3) return writedata[W-1:0];
        return '0;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_n    <= 0;
            m_cap  <= '0;
            m_mask <= '0;
            m_mode <= '0;
            m_rd   <= '0;
        end else begin
            if (m_n < HMAX) begin
                m_samp[m_n] <= in_port;
                m_n         <= m_n + 1;
            end
            m_rd  <= m_read(address);
            m_cap <= m_edges() | (m_cap & ~m_clear());
            if (chipselect && !write_n && address == 2'd1) m_mode <= writedata[15:0];
            if (chipselect && !write_n && address == 2'd2) m_mask <= writedata[W-1:0];
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        cyc();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address = a;
        cyc();
        d = readdata;
    endtask

    task automatic bus0_write(input logic [1:0] a, input logic [31:0] d);
        address0 = a; writedata0 = d; chipselect0 = 1'b1; write_n0 = 1'b0;
        cyc();
        chipselect0 = 1'b0; write_n0 = 1'b1;
    endtask

    task automatic bus0_read(input logic [1:0] a, output logic [31:0] d);
        address0 = a;
        cyc();
        d = readdata0;
    endtask

    task automatic test_reset();
        checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL rst_readdata got=%h exp=0", readdata); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq got=%b exp=0", irq); end
        checks++; if (readdata0 !== 32'h0) begin errors++; $display("FAIL rst_readdata0 got=%h exp=0", readdata0); end
        reset = 1'b0;
        address = 2'd3;
        for (int i = 0; i < 10; i++) begin
            cyc();
            checks++;
            if (readdata !== 32'h0) begin
                errors++; $display("FAIL prime_no_capture cycle=%0d got=%h exp=0", i, readdata);
            end
        end
        address = 2'd0;
        cyc();
        checks++; if (readdata !== 32'h0000_00FF) begin errors++; $display("FAIL data_read got=%h exp=000000ff", readdata); end
    endtask

    task automatic test_latency();
        logic [31:0] d;
        bus_write(2'd2, 32'h08);
        in_port = 8'h00;
        repeat (5) cyc();
        in_port = 8'h08;
        cyc();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL latency_c1 irq got=%b exp=0", irq); end
        cyc();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL latency_c2 irq got=%b exp=0", irq); end
        cyc();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL latency_c3 irq got=%b exp=1", irq); end
        bus_write(2'd3, 32'h08);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL w1c_irq got=%b exp=0", irq); end
        bus_read(2'd3, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL w1c_capture got=%h exp=0", d); end
    endtask

    task automatic test_edge_modes();
        logic [31:0] d;
        bus_write(2'd1, 32'h0009);
        bus_write(2'd3, 32'hFF);
        in_port = 8'h09;
        repeat (5) cyc();
        bus_read(2'd3, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rise_on_falling_bit got=%h exp=0", d); end
        in_port = 8'h0A;
        repeat (2) cyc();
        in_port = 8'h08;
        repeat (5) cyc();
        bus_read(2'd3, d);
        checks++; if (d !== 32'h03) begin errors++; $display("FAIL fall_and_both got=%h exp=03", d); end
        bus_read(2'd1, d);
        checks++; if (d !== 32'h0009) begin errors++; $display("FAIL mode_readback got=%h exp=0009", d); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL masked_irq got=%b exp=0", irq); end
        bus_write(2'd2, 32'h03);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL unmasked_irq got=%b exp=1", irq); end
        bus_write(2'd2, 32'h00);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL remask_irq got=%b exp=0", irq); end
        bus_read(2'd3, d);
        checks++; if (d !== 32'h03) begin errors++; $display("FAIL mask_keeps_capture got=%h exp=03", d); end
    endtask

    task automatic test_disabled();
        logic [31:0] d;
        bus_write(2'd1, 32'h0039);
        bus_read(2'd3, d);
        checks++; if (d !== 32'h03) begin errors++; $display("FAIL mode_write_keeps_capture got=%h exp=03", d); end
        bus_write(2'd3, 32'hFF);
        for (int i = 0; i < 6; i++) begin
            in_port = in_port ^ 8'h04;
            repeat (2) cyc();
        end
        repeat (5) cyc();
        bus_read(2'd3, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL disabled_bit got=%h exp=0", d); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        bus_write(2'd1, 32'h0);
        in_port = 8'h00;
        repeat (5) cyc();
        bus_write(2'd3, 32'hFF);
        in_port = 8'h01;
        repeat (2) cyc();
        bus_write(2'd3, 32'h01);
        bus_read(2'd3, d);
        checks++; if (d !== 32'h01) begin errors++; $display("FAIL edge_beats_clear got=%h exp=01", d); end
        in_port = 8'h03;
        repeat (2) cyc();
        bus_write(2'd3, 32'h01);
        bus_read(2'd3, d);
        checks++; if (d !== 32'h02) begin errors++; $display("FAIL clear_other_bit got=%h exp=02", d); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) in_port = 8'($urandom);
            address    = 2'($urandom_range(0, 3));
            chipselect = ($urandom_range(0, 3) == 0);
            write_n    = 1'($urandom_range(0, 1));
            writedata  = $urandom;
            cyc();
            checks++;
            if (readdata !== m_rd) begin
                errors++; $display("FAIL rand_readdata i=%0d got=%h exp=%h", i, readdata, m_rd);
            end
            checks++;
            if (irq !== |(m_cap & m_mask)) begin
                errors++; $display("FAIL rand_irq i=%0d got=%b exp=%b", i, irq, |(m_cap & m_mask));
            end
        end
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic test_clear_all_and_reset();
        logic [31:0] d;
        in_port0 = 8'hA5;
        repeat (5) cyc();
        bus0_read(2'd3, d);
        checks++; if (d !== 32'hA5) begin errors++; $display("FAIL ca_capture got=%h exp=a5", d); end
        bus0_write(2'd2, 32'hFF);
        checks++; if (irq0 !== 1'b1) begin errors++; $display("FAIL ca_irq_set got=%b exp=1", irq0); end
        bus0_write(2'd3, 32'h0);
        bus0_read(2'd3, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL ca_clear_all got=%h exp=0", d); end
        checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL ca_irq_clr got=%b exp=0", irq0); end
        in_port0 = 8'h00;
        repeat (3) cyc();
        in_port0 = 8'hA5;
        repeat (5) cyc();
        address0 = 2'd3;
        cyc();
        checks++; if (readdata0 !== 32'hA5) begin errors++; $display("FAIL ca_recapture got=%h exp=a5", readdata0); end
        checks++; if (irq0 !== 1'b1) begin errors++; $display("FAIL ca_irq_again got=%b exp=1", irq0); end
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL midrst_irq0 got=%b exp=0", irq0); end
        checks++; if (readdata0 !== 32'h0) begin errors++; $display("FAIL midrst_readdata0 got=%h exp=0", readdata0); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL midrst_irq got=%b exp=0", irq); end
        checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL midrst_readdata got=%h exp=0", readdata); end
        @(negedge clk);
        reset = 1'b0;
        repeat (8) cyc();
        bus0_read(2'd3, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL postrst_capture got=%h exp=0", d); end
        bus0_read(2'd2, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL postrst_mask got=%h exp=0", d); end
        bus0_read(2'd1, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL postrst_mode got=%h exp=0", d); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        address     = 2'd0;
        chipselect  = 1'b0;
        write_n     = 1'b1;
        writedata   = 32'h0;
        in_port     = 8'hFF;
        address0    = 2'd0;
        chipselect0 = 1'b0;
        write_n0    = 1'b1;
        writedata0  = 32'h0;
        in_port0    = 8'h00;
        repeat (3) cyc();
        test_reset();
        test_latency();
        test_edge_modes();
        test_disabled();
        test_back_to_back();
        test_random();
        test_clear_all_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/soc_system_pio_in_edge.md
Name: soc_system_pio_in_edge

Overview:
Parametrised Avalon-MM input PIO with a multi-bit input port. It provides:
- a synchroniser chain on the inputs;
- per-bit programmable edge detection (rising, falling, both, disabled);
- a sticky edge-capture register, with write-1-to-clear or clear-all selected at build time;
- a per-bit interrupt mask driving a level IRQ to the HPS.

It replaces single-bit rising-edge input PIOs in soc_system, such as the box request input.

Parameters:
WIDTH, 8, number of input bits (1..16).
SYNC_STAGES, 2, synchroniser flops per bit before edge detection (2..4).
BIT_CLEAR, 1, 1 = edge_capture write clears bits written as 1; 0 = any write to address 3 clears all bits.
EDGE_MODE_RST, 0, 2*WIDTH-bit reset value of the edge mode register (00 rising per bit).

Ports:
clk  in  1  system clock, all logic on posedge.
reset  in  1  asynchronous, active-high reset.
address  in  2  Avalon word address.
chipselect  in  1  Avalon chip select.
write_n  in  1  Avalon write strobe, active low.
writedata  in  32  Avalon write data.
readdata  out  32  Avalon read data, registered.
in_port  in  WIDTH  external asynchronous inputs.
irq  out  1  level interrupt, high while any unmasked capture bit is set.

Behaviour:
- Reset (async, active-high): readdata=0, edge_capture=0, irq_mask=0, edge_mode=EDGE_MODE_RST, sync chain=0, prime counter=0, irq=0.
- Sync chain:
  - in_port passes through SYNC_STAGES flops; s = last stage, p = s delayed one cycle.
  - Data register reads s, not raw in_port.
- Prime counter:
  - Counts 0..SYNC_STAGES+1 after reset, then saturates.
  - Edge detection is gated off until saturated.
  - This prevents a spurious edge when inputs are high at reset release.
- Per-bit edge detect (m = edge_mode[2i+1:2i]):
  - 00: s & ~p.
  - 01: ~s & p.
  - 10: s ^ p.
  - 11: never.
- Register map (write = chipselect & ~write_n):
  - addr 0: data, RO. Read = zero-extended s. Writes ignored.
  - addr 1: edge_mode, RW, bits [2*WIDTH-1:0]. Upper bits read 0.
  - addr 2: irq_mask, RW, bits [WIDTH-1:0].
  - addr 3: edge_capture. Read = capture bits.
    - Write with BIT_CLEAR=1: clear bits where writedata[i]=1.
    - Write with BIT_CLEAR=0: clear all bits.
- readdata:
  - Registered every clock from the mux on current address, independent of chipselect.
  - Read latency is 1 cycle.
- Capture update per bit, priority highest first:
  - edge detected -> set.
  - clear by write -> 0.
  - otherwise hold.
  - An edge in the same cycle as its clear leaves the bit set; no event is lost.
- edge_mode write:
  - Takes effect for detection the cycle after the write.
  - Does not alter existing capture bits.
- irq:
  - Combinational: |(edge_capture & irq_mask).
  - Masking a set bit drops irq without clearing the capture.
- Latency from an in_port transition to the capture bit set is SYNC_STAGES+1 clocks (after prime).
- Pulses shorter than one clk may be missed; this is not guaranteed.
- Reset asserted mid-operation clears all state immediately and re-arms the prime counter.

Test Plan:
1. WIDTH=8, SYNC_STAGES=2. Hold in_port=8'hFF through reset release -> edge_capture stays 0 for 10 cycles. Read addr 0 -> 32'h000000FF one cycle after address.
2. Default mode. Drive in_port bit3 0->1 -> capture bit3 set exactly 3 clocks later. With irq_mask=8'h08, irq goes 1. Write addr 3 data 8'h08 -> capture 0, irq 0 next cycle.
3. edge_mode=16'h0009 (bit0 falling, bit1 both). Toggle bit0 1->0 and bit1 0->1->0 -> capture reads 8'h03. A rising edge on bit0 alone sets nothing.
4. Set edge_mode bits 5:4=11 (bit2 disabled). Toggle bit2 repeatedly -> capture bit2 stays 0.
5. Align a clear write of 8'h01 with a detected edge on bit0 in the same cycle -> bit0 reads 1 afterwards. Repeat with the edge on bit1 only -> bit0 cleared, bit1 set.
6. BIT_CLEAR=0 build, capture=8'hA5. Write addr 3 any value -> capture 0. Assert reset mid-stream with capture/mask set -> all registers and irq 0 immediately.
